// File: rtl/circuit_stim_gen.sv
// LFSR stimulus source for `circuit` with an optional MISR response compactor.
// Define STIM_MISR_EN to add the sig_o signature port and compaction of y_i.

module circuit_stim_gen #(
    parameter int unsigned CNT_W = 8,
    parameter logic [31:0] SEED  = 32'hACE1_2468,
    parameter int unsigned Y_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_i,
    input  logic             pause_i,
    output logic             en_o,
    output logic [31:0]      x_o,
    input  logic [31:0]      y_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef STIM_MISR_EN
    output logic [31:0]      sig_o,
`endif
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [31:0]        LfsrTaps  = 32'h8020_0003;
    localparam int unsigned        DrainW    = 4;
    localparam logic [DrainW-1:0]  DrainLast = DrainW'(Y_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               en_q, en_d;
    logic [31:0]        x_q, x_d;
    logic               done_q, done_d;
    logic [DrainW-1:0]  drain_q, drain_d;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LfsrTaps) : (v >> 1);
    endfunction

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        x_d     = x_q;
        drain_d = drain_q;
        en_d    = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    lfsr_d = SEED;
                    cnt_d  = '0;
                    num_d  = num_i;
                    if (num_i == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!pause_i) begin
                    en_d   = 1'b1;
                    x_d    = lfsr_q;
                    lfsr_d = lfsr_step(lfsr_q);
                    cnt_d  = cnt_inc;
                    // Only the latched request is compared, so a full-scale num never wraps.
                    if (cnt_inc == num_q) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                // Spans Y_LAT+1 cycles so done lands Y_LAT+1 edges after the last issue edge.
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            num_q   <= '0;
            en_q    <= 1'b0;
            x_q     <= '0;
            done_q  <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            en_q    <= en_d;
            x_q     <= x_d;
            done_q  <= done_d;
            drain_q <= drain_d;
        end
    end

    assign en_o   = en_q;
    assign x_o    = x_q;
    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign cnt_o  = cnt_q;

`ifdef STIM_MISR_EN
    logic [Y_LAT-1:0] vld_q, vld_d;
    logic [31:0]      sig_q, sig_d;
    logic             y_vld;

    assign y_vld = vld_q[Y_LAT-1];

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = en_q;
        sig_d    = sig_q;
        if (state_q == StIdle && start_i) begin
            sig_d = '0;
        end else if (y_vld) begin
            sig_d = {sig_q[30:0], sig_q[31]} ^ y_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            sig_q <= '0;
        end else begin
            vld_q <= vld_d;
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;
`else
    logic unused_y;
    assign unused_y = ^y_i;
`endif

endmodule

// File: tb/tb_circuit_stim_gen.sv
// Scoreboard bench for circuit_stim_gen: driver pushes expected samples/completions,
// a negedge monitor pops and compares. Signature checked when STIM_MISR_EN is defined.

module tb_circuit_stim_gen;

    localparam int          CNT_W = 8;
    localparam int          Y_LAT = 1;
    localparam logic [31:0] SEED  = 32'hACE1_2468;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [CNT_W-1:0] num_i;
    logic             pause_i;
    logic             en_o;
    logic [31:0]      x_o;
    logic [31:0]      y_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] cnt_o;
`ifdef STIM_MISR_EN
    logic [31:0]      sig_o;
`endif

    circuit_stim_gen dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .num_i   (num_i),
        .pause_i (pause_i),
        .en_o    (en_o),
        .x_o     (x_o),
        .y_i     (y_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
`ifdef STIM_MISR_EN
        .sig_o   (sig_o),
`endif
        .cnt_o   (cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // y follows x one cycle later, matching Y_LAT=1.
`ifdef STIM_MISR_EN
    always @(posedge clk) y_i <= x_o;
`else
    always @(posedge clk) y_i <= $urandom;
`endif

    typedef struct {
        int          cyc;
        int          cnt;
        logic [31:0] sig;
    } done_t;

    logic [31:0] exp_x[$];
    done_t       exp_done[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        if (v[0]) return (v >> 1) ^ 32'h8020_0003;
        return v >> 1;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v);
        return {v[30:0], v[31]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of its queue.
    initial begin
        done_t rec;
        forever begin
            @(negedge clk);
            if (en_o === 1'b1) begin
                if (exp_x.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL x_unexpected: en high with x=0x%08h, none expected (cycle %0d)",
                             x_o, cyc);
                end else begin
                    chk("x_sample", x_o, exp_x.pop_front());
                    chk("busy_during_en", 32'(busy_o), 32'd1);
                end
            end
            if (done_o === 1'b1) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: done high, none expected (cycle %0d)", cyc);
                end else begin
                    rec = exp_done.pop_front();
                    chk("done_cycle", cyc, rec.cyc);
                    chk("done_cnt", 32'(cnt_o), rec.cnt);
                    chk("busy_at_done", 32'(busy_o), 32'd1);
`ifdef STIM_MISR_EN
                    chk("sig_at_done", sig_o, rec.sig);
`endif
                end
            end
        end
    end

    // One run from IDLE. Pause slots come from pat (first 32 slots) OR'd with random pauses.
    task automatic run(input int n, input int pct, input logic [31:0] pat);
        logic        pz[$];
        logic [31:0] xs[$];
        logic [31:0] lf;
        logic [31:0] sg;
        logic        b;
        int          issued;
        int          slot;
        done_t       rec;
        lf     = SEED;
        sg     = '0;
        issued = 0;
        slot   = 0;
        while (issued < n) begin
            b = ((slot < 32) && pat[slot]) || (int'($urandom_range(99)) < pct);
            pz.push_back(b);
            if (!b) begin
                xs.push_back(lf);
                sg = rotl(sg) ^ lf;
                lf = lfsr_next(lf);
                issued++;
            end
            slot++;
        end
        // Start edge E0 is the next posedge; done follows edge E0+slots+Y_LAT+1.
        rec.cyc = (n == 0) ? cyc + 1 : cyc + 1 + pz.size() + Y_LAT + 1;
        rec.cnt = n;
        rec.sig = sg;
        exp_done.push_back(rec);

        start_i = 1'b1;
        num_i   = CNT_W'(n);
        pause_i = 1'($urandom);
        @(negedge clk);
        foreach (pz[i]) begin
            start_i = 1'($urandom);
            num_i   = CNT_W'($urandom);
            pause_i = pz[i];
            if (!pz[i]) exp_x.push_back(xs.pop_front());
            @(negedge clk);
        end
        while (cyc <= rec.cyc) begin
            start_i = 1'($urandom);
            num_i   = CNT_W'($urandom);
            pause_i = 1'($urandom);
            @(negedge clk);
        end
        start_i = 1'b0;
        pause_i = 1'b0;
        chk("busy_after_run", 32'(busy_o), 32'd0);
        chk("cnt_hold", 32'(cnt_o), n);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_en"}, 32'(en_o), 32'd0);
        chk({tag, "_x"}, x_o, 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_cnt"}, 32'(cnt_o), 32'd0);
`ifdef STIM_MISR_EN
        chk({tag, "_sig"}, sig_o, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        num_i   = '0;
        pause_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_en", 32'(en_o), 32'd0);
        end

        run(3, 0, 32'h0);
        run(4, 0, 32'h0000_001C);
        run(0, 0, 32'h0);

        // Reset after the second sample of a 10-sample run: no done, back to IDLE.
        start_i = 1'b1;
        num_i   = CNT_W'(10);
        pause_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        exp_x.push_back(SEED);
        @(negedge clk);
        exp_x.push_back(lfsr_next(SEED));
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_reset_values("midrun_reset");
        repeat (3) @(negedge clk);
        chk("post_reset_busy", 32'(busy_o), 32'd0);

        run(3, 0, 32'h0);
        run(255, 0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            run(int'($urandom_range(12)), 30, 32'h0);
        end

        repeat (4) @(negedge clk);
        chk("x_queue_drained", exp_x.size(), 32'd0);
        chk("done_queue_drained", exp_done.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
